memory_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single 64K memory (ROM 0000H–07FFH, RAM 0800H–FFFFH).
- Shares the memory between requester 0 (CPU/MDR path) and requester 1 (monitor/keyboard loader DMA path) using round-robin.
- Drives memory address and nCE, and owns the bidirectional data bus while writing.
- Returns read data and a one-cycle ack to the requester that was served.

---
 rtl/memory_arbiter.sv | 120 ++++++++++++
 tb/tb_memory_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin two-port arbiter/sequencer for the shared 64K memory (IDLE -> ACCESS -> RESP).
// Optional ROM write protection is enabled by defining ROM_PROTECT_EN.
module memory_arbiter #(
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] ROM_TOP     = 16'h07FF
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [7:0]  wdata0,
    output logic [7:0]  rdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata1,
    output logic [7:0]  rdata1,
    output logic        ack1,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic        mem_nCE,
    inout  wire  [7:0]  mem_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] WS       = 4'(WAIT_STATES);

`ifdef ROM_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_last;
    logic        r_gnt;
    logic        r_we;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata0;
    logic [7:0]  r_rdata1;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_err;

    logic        w_gnt;
    logic        w_block;
    logic        w_drive;

    // On a tie the requester that was not served last wins; otherwise whoever is asking.
    assign w_gnt   = (req0 && req1) ? ~r_last : req1;
    assign w_block = PROT_EN & r_we & (r_addr <= ROM_TOP);
    assign w_drive = (r_state == S_ACCESS) && r_we && !w_block;

    assign mem_nCE  = ~w_drive;
    assign mem_data = w_drive ? r_wdata : 8'hzz;
    assign mem_addr = r_addr;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign err      = r_err;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_last   <= 1'b1;
            r_gnt    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 16'h0000;
            r_wdata  <= 8'h00;
            r_rdata0 <= 8'h00;
            r_rdata1 <= 8'h00;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_gnt   <= w_gnt;
                        r_last  <= w_gnt;
                        r_we    <= w_gnt ? we1    : we0;
                        r_addr  <= w_gnt ? addr1  : addr0;
                        r_wdata <= w_gnt ? wdata1 : wdata0;
                        r_cnt   <= WS;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            if (r_gnt) r_rdata1 <= mem_data;
                            else       r_rdata0 <= mem_data;
                        end
                        // ack/err registered here so they are high during RESP
                        r_ack0  <= ~r_gnt;
                        r_ack1  <= r_gnt;
                        r_err   <= w_block;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a transaction-level model of memory and grant order.
// Uses a zero-wait-state instance for most checks and a three-wait-state instance for timing.
module tb_memory_arbiter;

`ifdef ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic CLR = 1'b0;

    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0;
    logic [7:0]  wdata0 = 0, wdata1 = 0;
    wire  [7:0]  rdata0, rdata1, mem_data;
    wire         ack0, ack1, err, mem_nCE;
    wire  [15:0] mem_addr;

    logic        req0_b = 0, we0_b = 0;
    logic [15:0] addr0_b = 0;
    logic [7:0]  wdata0_b = 0;
    wire  [7:0]  rdata0_b, rdata1_b, mem_data_b;
    wire         ack0_b, ack1_b, err_b, mem_nCE_b;
    wire  [15:0] mem_addr_b;

    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:65535];
    logic [7:0] ref_a [0:65535];

    memory_arbiter #(.WAIT_STATES(0)) u_dut (
        .CLK(CLK), .CLR(CLR),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
        .err(err), .mem_addr(mem_addr), .mem_nCE(mem_nCE), .mem_data(mem_data));

    memory_arbiter #(.WAIT_STATES(3)) u_dut_b (
        .CLK(CLK), .CLR(CLR),
        .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .rdata0(rdata0_b), .ack0(ack0_b),
        .req1(1'b0), .we1(1'b0), .addr1(16'h0000), .wdata1(8'h00), .rdata1(rdata1_b), .ack1(ack1_b),
        .err(err_b), .mem_addr(mem_addr_b), .mem_nCE(mem_nCE_b), .mem_data(mem_data_b));

    // Asynchronous-read, edge-write memories: drive the bus whenever nCE is high.
    assign mem_data   = mem_nCE   ? mem_a[mem_addr]   : 8'hzz;
    assign mem_data_b = mem_nCE_b ? mem_b[mem_addr_b] : 8'hzz;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem_a[i] <= (i < 16'h0800) ? 8'(i) : 8'h00;
            mem_b[i] <= (i < 16'h0800) ? 8'(i) : 8'h00;
        end
    end
    always @(posedge CLK) if (mem_nCE === 1'b0) mem_a[mem_addr] <= mem_data;
    always @(posedge CLK) if (mem_nCE_b === 1'b0) mem_b[mem_addr_b] <= mem_data_b;

    int nce_lo = 0, nce_lo_b = 0, both_cnt = 0, busx = 0;
    always @(negedge CLK) begin
        if (mem_nCE === 1'b0) nce_lo++;
        if (mem_nCE_b === 1'b0) nce_lo_b++;
        if (ack0 && ack1) both_cnt++;
        if (^mem_data === 1'bx) busx++;
    end

    int n_chk = 0, n_pass = 0;
    int nxt = 0;  // requester that wins the next tie

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit blocked(input bit we, input logic [15:0] a);
        return PROT && we && (a <= 16'h07FF);
    endfunction

    function automatic logic get_ack(input int r);
        return (r != 0) ? ack1 : ack0;
    endfunction

    function automatic logic [7:0] get_rdata(input int r);
        return (r != 0) ? rdata1 : rdata0;
    endfunction

    task automatic set_req(input int r, input bit rq, input bit we, input logic [15:0] a, input logic [7:0] d);
        if (r == 0) begin req0 = rq; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = rq; we1 = we; addr1 = a; wdata1 = d; end
    endtask

    // Called in the ack cycle of requester r: check its result and advance the model.
    task automatic serve(input int r, input bit we, input logic [15:0] a, input logic [7:0] d);
        if (!we) chk("rdata", get_rdata(r), ref_a[a]);
        chk("err", err, blocked(we, a));
        if (we && !blocked(we, a)) ref_a[a] = d;
        nxt = 1 - r;
    endtask

    task automatic single(input int r, input bit we, input logic [15:0] a, input logic [7:0] d, output int nce);
        int lat, n0;
        logic [7:0] exp_rd;
        exp_rd = ref_a[a];
        @(posedge CLK); #1;
        set_req(r, 1'b1, we, a, d);
        n0 = nce_lo;
        lat = 0;
        do begin @(negedge CLK); lat++; end while (!get_ack(r) && lat < 30);
        chk("latency", lat, 3);
        chk("other_ack", get_ack(1 - r), 1'b0);
        serve(r, we, a, d);
        @(posedge CLK); #1;
        set_req(r, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge CLK);
        chk("ack_width", get_ack(r), 1'b0);
        if (!we) chk("rdata_hold", get_rdata(r), exp_rd);
        nce = nce_lo - n0;
    endtask

    bit          q_we [2][4];
    logic [15:0] q_a  [2][4];
    logic [7:0]  q_d  [2][4];
    int          q_n  [2];

    task automatic dual();
        int idx [2];
        int lat, g, e;
        idx[0] = 0; idx[1] = 0;
        @(posedge CLK); #1;
        for (int r = 0; r < 2; r++) set_req(r, 1'b1, q_we[r][0], q_a[r][0], q_d[r][0]);
        while (idx[0] < q_n[0] || idx[1] < q_n[1]) begin
            lat = 0;
            do begin @(negedge CLK); lat++; end while (!ack0 && !ack1 && lat < 30);
            if (lat >= 30) begin
                chk("dual_timeout", lat, 0);
                break;
            end
            chk("both_ack", {31'd0, ack0 && ack1}, 0);
            g = ack1 ? 1 : 0;
            if (idx[0] < q_n[0] && idx[1] < q_n[1]) e = nxt;
            else e = (idx[0] < q_n[0]) ? 0 : 1;
            chk("grant", g, e);
            serve(g, q_we[g][idx[g]], q_a[g][idx[g]], q_d[g][idx[g]]);
            idx[g]++;
            @(posedge CLK); #1;
            if (idx[g] < q_n[g]) set_req(g, 1'b1, q_we[g][idx[g]], q_a[g][idx[g]], q_d[g][idx[g]]);
            else set_req(g, 1'b0, 1'b0, 16'h0000, 8'h00);
        end
        set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge CLK);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 7));
            1:       return 16'h07FE + 16'($urandom_range(0, 3));
            2:       return 16'h0900 + 16'($urandom_range(0, 7));
            default: return 16'hFFF8 + 16'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        int nce, lat, acnt, n0;
        logic seen;
        for (int i = 0; i < 65536; i++) ref_a[i] = (i < 16'h0800) ? 8'(i) : 8'h00;

        #2 CLR = 1'b1;
        #1;
        chk("rst_nce", mem_nCE, 1'b1);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_acks", {ack0, ack1, err}, 3'b000);
        chk("rst_rdata", {rdata0, rdata1}, 16'h0000);
        @(posedge CLK); @(posedge CLK); #1 CLR = 1'b0;

        single(0, 1'b0, 16'h0003, 8'h00, nce);
        chk("rd0003", rdata0, 8'h03);
        chk("rd_nce", nce, 0);

        single(1, 1'b1, 16'h0900, 8'h20, nce);
        chk("wr_nce", nce, 1);
        chk("mem0900", mem_a[16'h0900], 8'h20);
        single(1, 1'b0, 16'h0900, 8'h00, nce);
        chk("rd0900", rdata1, 8'h20);

        q_n[0] = 2; q_n[1] = 2;
        for (int k = 0; k < 2; k++) begin
            q_we[0][k] = 1'b0; q_a[0][k] = 16'h0800; q_d[0][k] = 8'h00;
            q_we[1][k] = 1'b0; q_a[1][k] = 16'h0801; q_d[1][k] = 8'h00;
        end
        dual();

        // Abort a write by reset during its ACCESS cycle.
        @(posedge CLK); #1;
        set_req(0, 1'b1, 1'b1, 16'h0A00, 8'h55);
        @(posedge CLK); #2;
        CLR = 1'b1;
        #1;
        chk("clr_nce", mem_nCE, 1'b1);
        chk("clr_addr", mem_addr, 16'h0000);
        chk("clr_acks", {ack0, ack1, err}, 3'b000);
        chk("clr_rdata", {rdata0, rdata1}, 16'h0000);
        set_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(posedge CLK); #1 CLR = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(negedge CLK); seen = seen | ack0 | ack1; end
        chk("clr_no_ack", seen, 1'b0);
        chk("mem0A00", mem_a[16'h0A00], 8'h00);
        nxt = 0;

        single(0, 1'b1, 16'h0005, 8'hAA, nce);
        chk("rom_wr_nce", nce, PROT ? 0 : 1);
        chk("mem0005", mem_a[16'h0005], PROT ? 8'h05 : 8'hAA);

        // Three-wait-state instance: read timing and address hold.
        @(posedge CLK); #1;
        req0_b = 1'b1; we0_b = 1'b0; addr0_b = 16'h0010;
        lat = 0; acnt = 0;
        do begin
            @(negedge CLK); lat++;
            if (lat >= 2 && lat <= 5 && mem_addr_b == 16'h0010) acnt++;
        end while (!ack0_b && lat < 30);
        chk("ws3_latency", lat, 6);
        chk("ws3_addr_hold", acnt, 4);
        chk("ws3_rdata", rdata0_b, 8'h10);
        @(posedge CLK); #1 req0_b = 1'b0;
        @(posedge CLK); #1;
        req0_b = 1'b1; we0_b = 1'b1; addr0_b = 16'h0801; wdata0_b = 8'h77;
        n0 = nce_lo_b; lat = 0;
        do begin @(negedge CLK); lat++; end while (!ack0_b && lat < 30);
        chk("ws3_wr_latency", lat, 6);
        chk("ws3_wr_nce", nce_lo_b - n0, 4);
        chk("ws3_mem0801", mem_b[16'h0801], 8'h77);
        @(posedge CLK); #1 req0_b = 1'b0;

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                single(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(),
                       8'($urandom), nce);
            end else begin
                for (int r = 0; r < 2; r++) begin
                    q_n[r] = int'($urandom_range(1, 4));
                    for (int k = 0; k < 4; k++) begin
                        q_we[r][k] = 1'($urandom_range(0, 1));
                        q_a[r][k]  = pick_addr();
                        q_d[r][k]  = 8'($urandom);
                    end
                end
                dual();
            end
        end

        chk("never_both_acks", both_cnt, 0);
        chk("bus_never_x", busx, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
